// File: rtl/la_gpio_irqctrl.sv
// GPIO bank controller: output/OE registers, synchronized inputs, level/edge events into W1C STATUS, one IRQ.
// Optional per-pin input debounce filter when LA_GPIO_DEBOUNCE_EN is defined.
module la_gpio_irqctrl #(
  parameter int N   = 8,
  parameter int DBW = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reg_valid,
  input  logic         reg_write,
  input  logic [2:0]   reg_addr,
  input  logic [N-1:0] reg_wdata,
  output logic         reg_ready,
  output logic         reg_rvalid,
  output logic [N-1:0] reg_rdata,
  input  logic         reg_rready,
  input  logic [N-1:0] gpio_in,
  output logic [N-1:0] gpio_out,
  output logic [N-1:0] gpio_oe,
  output logic         gpio_irq
);

  localparam logic [2:0] ADDR_OUT    = 3'd0;
  localparam logic [2:0] ADDR_OE     = 3'd1;
  localparam logic [2:0] ADDR_IN     = 3'd2;
  localparam logic [2:0] ADDR_IRQEN  = 3'd3;
  localparam logic [2:0] ADDR_TYPE   = 3'd4;
  localparam logic [2:0] ADDR_POL    = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;
  localparam logic [2:0] ADDR_DBNC   = 3'd7;

  logic [N-1:0] out_q, out_d, oe_q, oe_d, en_q, en_d;
  logic [N-1:0] type_q, type_d, pol_q, pol_d, status_q, status_d;
  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [N-1:0] rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d, irq_q, irq_d;
  logic         accept, wr_en, rd_en;
  logic [N-1:0] det_s, det_sd, ev, w1c, rd_word;

  // Handshake: a request is taken when reg_valid & reg_ready; a read response
  // (reg_rvalid/reg_rdata) is held until the cycle in which reg_rready is high.
  always_comb begin
    reg_ready = ~rvalid_q | reg_rready;
    accept    = reg_valid & reg_ready;
    wr_en     = accept & reg_write;
    rd_en     = accept & ~reg_write;
  end

`ifdef LA_GPIO_DEBOUNCE_EN
  logic [DBW-1:0] dbnc_q, dbnc_d;
  logic [DBW-1:0] cnt_q [N];
  logic [DBW-1:0] cnt_d [N];
  logic [DBW-1:0] eff   [N];
  logic [N-1:0]   f_q, f_d, fd_q;

  // eff = cycles s2 has been stable minus one; f follows s2 once eff reaches DBNC.
  always_comb begin
    dbnc_d = (wr_en && reg_addr == ADDR_DBNC) ? DBW'(reg_wdata) : dbnc_q;
    f_d    = f_q;
    for (int i = 0; i < N; i++) begin
      eff[i]   = (s2_q[i] != s3_q[i]) ? '0 : cnt_q[i];
      cnt_d[i] = (&eff[i]) ? eff[i] : eff[i] + DBW'(1);
      if (eff[i] >= dbnc_q) f_d[i] = s2_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dbnc_q <= '0;
      f_q    <= '0;
      fd_q   <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      dbnc_q <= dbnc_d;
      f_q    <= f_d;
      fd_q   <= f_q;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign det_s  = f_q;
  assign det_sd = fd_q;
`else
  assign det_s  = s2_q;
  assign det_sd = s3_q;
`endif

  always_comb begin
    ev       = ~(det_s ^ pol_q) & (~type_q | (det_s ^ det_sd));
    w1c      = (wr_en && reg_addr == ADDR_STATUS) ? reg_wdata : '0;
    status_d = ev | (status_q & ~w1c);
    out_d    = (wr_en && reg_addr == ADDR_OUT)   ? reg_wdata : out_q;
    oe_d     = (wr_en && reg_addr == ADDR_OE)    ? reg_wdata : oe_q;
    en_d     = (wr_en && reg_addr == ADDR_IRQEN) ? reg_wdata : en_q;
    type_d   = (wr_en && reg_addr == ADDR_TYPE)  ? reg_wdata : type_q;
    pol_d    = (wr_en && reg_addr == ADDR_POL)   ? reg_wdata : pol_q;
    irq_d    = |(status_d & en_d);
    case (reg_addr)
      ADDR_OUT:    rd_word = out_q;
      ADDR_OE:     rd_word = oe_q;
      ADDR_IN:     rd_word = det_s;
      ADDR_IRQEN:  rd_word = en_q;
      ADDR_TYPE:   rd_word = type_q;
      ADDR_POL:    rd_word = pol_q;
      ADDR_STATUS: rd_word = status_q;
`ifdef LA_GPIO_DEBOUNCE_EN
      default:     rd_word = N'(dbnc_q);
`else
      default:     rd_word = '0;
`endif
    endcase
    rdata_d  = rd_en ? rd_word : rdata_q;
    rvalid_d = rd_en ? 1'b1 : (reg_rready ? 1'b0 : rvalid_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q    <= '0;
      oe_q     <= '0;
      en_q     <= '0;
      type_q   <= '0;
      pol_q    <= '0;
      status_q <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      oe_q     <= oe_d;
      en_q     <= en_d;
      type_q   <= type_d;
      pol_q    <= pol_d;
      status_q <= status_d;
      s1_q     <= gpio_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign reg_rvalid = rvalid_q;
  assign reg_rdata  = rdata_q;
  assign gpio_out   = out_q;
  assign gpio_oe    = oe_q;
  assign gpio_irq   = irq_q;

endmodule
